music_tone_player: RTL and testbench

//  Multi-channel buzzer tone player; successor to the fixed single-note frequency lookup.

---
 rtl/music_tone_if.sv | 26 ++
 rtl/music_tone_player.sv | 174 +++++++++++++++++
 tb/tb_music_tone_player.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/music_tone_if.sv
// Note request / status bundle for music_tone_player.
// The master side drives the note requests and the slave side is the player.
interface music_tone_if #(
    parameter int NUM_CH    = 2,
    parameter int DUR_WIDTH = 8
);
    logic [NUM_CH*12-1:0]        note_code;
    logic [NUM_CH*DUR_WIDTH-1:0] note_dur;
    logic [NUM_CH-1:0]           note_valid;
    logic [NUM_CH-1:0]           note_ready;
    logic [NUM_CH-1:0]           busy;
    logic [NUM_CH-1:0]           note_done;
    logic [NUM_CH-1:0]           bad_code;
    logic [NUM_CH-1:0]           tone_out;
    logic                        tone_mix;

    modport master (
        output note_code, note_dur, note_valid,
        input  note_ready, busy, note_done, bad_code, tone_out, tone_mix
    );

    modport slave (
        input  note_code, note_dur, note_valid,
        output note_ready, busy, note_done, bad_code, tone_out, tone_mix
    );
endinterface

// File: rtl/music_tone_player.sv
// Multi-channel buzzer tone player: per-channel note decode, preset-load square wave, beat timing.
// Optional MUSIC_TONE_GAP_EN inserts a one-beat silent gap after every note.
module music_tone_player #(
    parameter int NUM_CH    = 2,
    parameter int CNT_WIDTH = 14,
    parameter int DUR_WIDTH = 8,
    parameter int PRE_DIV   = 4,
    parameter int BEAT_DIV  = 2500000
) (
    input  logic         clk,
    input  logic         rst,
    music_tone_if.slave  bus
);
    localparam logic [CNT_WIDTH-1:0] MAX = '1;
    localparam int PW = $clog2(PRE_DIV + 1);
    localparam int BW = $clog2(BEAT_DIV + 1);
    localparam logic [PW-1:0] PRE_LAST  = PW'(PRE_DIV - 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_DIV - 1);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    function automatic logic [13:0] table_t(input logic [1:0] row, input logic [2:0] idx);
        logic [13:0] t;
        t = 14'd16383;
        case ({row, idx})
            {2'd0, 3'd1}: t = 14'd4915;
            {2'd0, 3'd2}: t = 14'd6168;
            {2'd0, 3'd3}: t = 14'd7281;
            {2'd0, 3'd4}: t = 14'd7792;
            {2'd0, 3'd5}: t = 14'd8730;
            {2'd0, 3'd6}: t = 14'd9565;
            {2'd0, 3'd7}: t = 14'd10310;
            {2'd1, 3'd1}: t = 14'd10647;
            {2'd1, 3'd2}: t = 14'd11272;
            {2'd1, 3'd3}: t = 14'd11831;
            {2'd1, 3'd4}: t = 14'd12094;
            {2'd1, 3'd5}: t = 14'd12556;
            {2'd1, 3'd6}: t = 14'd12947;
            {2'd1, 3'd7}: t = 14'd13346;
            {2'd2, 3'd1}: t = 14'd13516;
            {2'd2, 3'd2}: t = 14'd13829;
            {2'd2, 3'd3}: t = 14'd14109;
            {2'd2, 3'd4}: t = 14'd14235;
            {2'd2, 3'd5}: t = 14'd14470;
            {2'd2, 3'd6}: t = 14'd14678;
            {2'd2, 3'd7}: t = 14'd14864;
            default:      t = 14'd16383;
        endcase
        return t;
    endfunction

    // Returns {illegal, preset}; illegal codes and the rest code both load MAX (silent).
    function automatic logic [CNT_WIDTH:0] decode_note(input logic [11:0] code);
        logic        illegal;
        logic [1:0]  nz;
        logic [13:0] t;
        nz = {1'b0, |code[11:8]} + {1'b0, |code[7:4]} + {1'b0, |code[3:0]};
        illegal = code[11] | code[7] | code[3] | (nz > 2'd1);
        if (illegal)               t = 14'h3FFF;
        else if (code[10:8] != '0) t = table_t(2'd2, code[10:8]);
        else if (code[6:4] != '0)  t = table_t(2'd1, code[6:4]);
        else                       t = table_t(2'd0, code[2:0]);
        return {illegal, MAX - CNT_WIDTH'(14'h3FFF - t)};
    endfunction

    logic [NUM_CH-1:0] ready_v, busy_v, done_v, bad_v, tone_v;
    logic              mix_p1;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t                 state, state_nxt;
        logic [CNT_WIDTH-1:0]   cnt, preset;
        logic [PW-1:0]          pre;
        logic [BW-1:0]          beat_clk;
        logic [DUR_WIDTH-1:0]   beats, dur;
        logic                   tone, done, bad;
        logic                   accept, tone_en, play_end, gap_end;
        logic [CNT_WIDTH:0]     dec;

        assign dec      = decode_note(bus.note_code[12*i +: 12]);
        assign accept   = bus.note_valid[i] && (state == IDLE);
        assign tone_en  = (state == PLAY) && (pre == PRE_LAST);
        assign play_end = (dur == '0) || ((beat_clk == BEAT_LAST) && (beats == dur - 1'b1));
        assign gap_end  = (beat_clk == BEAT_LAST);

        always_ff @(posedge clk) begin
            if (rst) state <= IDLE;
            else     state <= state_nxt;
        end

        always_comb begin
            state_nxt = state;
            case (state)
                IDLE: if (accept) state_nxt = PLAY;
                PLAY: if (play_end) begin
`ifdef MUSIC_TONE_GAP_EN
                    state_nxt = GAP;
`else
                    state_nxt = IDLE;
`endif
                end
                GAP:  if (gap_end) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt      <= '0;
                preset   <= '0;
                pre      <= '0;
                beat_clk <= '0;
                beats    <= '0;
                dur      <= '0;
                tone     <= 1'b0;
                done     <= 1'b0;
                bad      <= 1'b0;
            end else begin
                done <= (state != IDLE) && (state_nxt == IDLE);
                bad  <= accept && dec[CNT_WIDTH];
                if (accept) begin
                    preset   <= dec[CNT_WIDTH-1:0];
                    cnt      <= dec[CNT_WIDTH-1:0];
                    dur      <= bus.note_dur[DUR_WIDTH*i +: DUR_WIDTH];
                    pre      <= '0;
                    beat_clk <= '0;
                    beats    <= '0;
                    tone     <= 1'b0;
                end else if (state == PLAY) begin
                    pre <= (pre == PRE_LAST) ? '0 : pre + 1'b1;
                    if (tone_en) begin
                        if (cnt == MAX) begin
                            cnt <= preset;
                            if (preset != MAX) tone <= ~tone;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    if (beat_clk == BEAT_LAST) begin
                        beat_clk <= '0;
                        beats    <= beats + 1'b1;
                    end else begin
                        beat_clk <= beat_clk + 1'b1;
                    end
                    // Leaving PLAY silences the pin and rearms the beat timer for a gap.
                    if (play_end) begin
                        tone     <= 1'b0;
                        beat_clk <= '0;
                    end
                end else if (state == GAP) begin
                    beat_clk <= gap_end ? '0 : beat_clk + 1'b1;
                end
            end
        end

        assign ready_v[i] = (state == IDLE);
        assign busy_v[i]  = (state != IDLE);
        assign done_v[i]  = done;
        assign bad_v[i]   = bad;
        assign tone_v[i]  = tone;
    end

    // Stage p1: registered mix of all channel tones.
    always_ff @(posedge clk) begin
        if (rst) mix_p1 <= 1'b0;
        else     mix_p1 <= |tone_v;
    end

    assign bus.note_ready = ready_v;
    assign bus.busy       = busy_v;
    assign bus.note_done  = done_v;
    assign bus.bad_code   = bad_v;
    assign bus.tone_out   = tone_v;
    assign bus.tone_mix   = mix_p1;
endmodule

// File: tb/tb_music_tone_player.sv
// Bench for music_tone_player: note table, directed corner sequences and random traffic
// checked every cycle against a timeline model of each channel.
module tb_music_tone_player;
    localparam int NCH = 2;
    localparam int DW  = 8;
    localparam int BD  = 4000;
`ifdef MUSIC_TONE_GAP_EN
    localparam int GAP_LEN = BD;
`else
    localparam int GAP_LEN = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    music_tone_if #(.NUM_CH(NCH), .DUR_WIDTH(DW)) bus ();

    music_tone_player #(
        .NUM_CH(NCH), .CNT_WIDTH(14), .DUR_WIDTH(DW), .PRE_DIV(1), .BEAT_DIV(BD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_err = 0;
    int n_chk = 0;
    int mdl_fail = 0;
    bit chk_en = 1'b0;
    longint cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        n_chk++;
        if (act !== 32'(exp)) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Note preset table (row = nibble position: low, med, high; column = nibble value).
    int t_tab [3][8] = '{
        '{16383, 4915, 6168, 7281, 7792, 8730, 9565, 10310},
        '{16383, 10647, 11272, 11831, 12094, 12556, 12947, 13346},
        '{16383, 13516, 13829, 14109, 14235, 14470, 14678, 14864}};

    // Half period in clocks (0 = silent) and illegal flag, straight from the note rules.
    function automatic void ref_decode(input logic [11:0] code, output int half, output bit bad);
        int nz, row, idx;
        nz = 0; row = 0; idx = 0; bad = 1'b0;
        for (int r = 0; r < 3; r++) begin
            int nib;
            nib = int'(code >> (4 * r)) & 15;
            if (nib != 0) begin nz++; row = r; idx = nib; end
            if (nib > 7) bad = 1'b1;
        end
        if (nz > 1) bad = 1'b1;
        if (bad || nz == 0) half = 0;
        else                half = 16384 - t_tab[row][idx & 7];
    endfunction

    // Timeline model: each channel remembers when its current note was accepted.
    bit     m_has [NCH];
    longint m_start [NCH];
    int     m_play [NCH], m_busy [NCH], m_half [NCH];
    bit     m_bad [NCH];
    bit     prev_tone [NCH];

    function automatic void exp_ch(input int ch, output bit b, output bit d, output bit bd, output bit t);
        longint k;
        b = 0; d = 0; bd = 0; t = 0;
        if (m_has[ch]) begin
            k  = cyc - m_start[ch];
            b  = (k >= 1) && (k <= m_busy[ch]);
            d  = (k == m_busy[ch] + 1);
            bd = m_bad[ch] && (k == 1);
            t  = b && (k <= m_play[ch]) && (m_half[ch] != 0) && (((k - 1) / m_half[ch]) % 2 == 1);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    logic [NCH-1:0] e_rdy, e_busy, e_done, e_bad, e_tone;
    logic           e_mix;
    always @(negedge clk) begin
        for (int ch = 0; ch < NCH; ch++) begin
            bit b, d, bd, t;
            exp_ch(ch, b, d, bd, t);
            e_busy[ch] = b; e_rdy[ch] = !b; e_done[ch] = d; e_bad[ch] = bd; e_tone[ch] = t;
        end
        e_mix = prev_tone[0] | prev_tone[1];
        if (chk_en && mdl_fail < 10) begin
            n_chk++;
            if ({bus.note_ready, bus.busy, bus.note_done, bus.bad_code, bus.tone_out, bus.tone_mix}
                !== {e_rdy, e_busy, e_done, e_bad, e_tone, e_mix}) begin
                n_err++;
                mdl_fail++;
                $display("FAIL model cycle %0d: got rdy=%b busy=%b done=%b bad=%b tone=%b mix=%b expected rdy=%b busy=%b done=%b bad=%b tone=%b mix=%b",
                         cyc, bus.note_ready, bus.busy, bus.note_done, bus.bad_code, bus.tone_out, bus.tone_mix,
                         e_rdy, e_busy, e_done, e_bad, e_tone, e_mix);
            end
        end
        for (int ch = 0; ch < NCH; ch++) begin
            prev_tone[ch] = rst ? 1'b0 : e_tone[ch];
            if (rst) begin
                m_has[ch] = 1'b0;
            end else if (bus.note_valid[ch] && e_rdy[ch]) begin
                int h, d;
                bit bd;
                ref_decode(bus.note_code[12*ch +: 12], h, bd);
                d = int'(bus.note_dur[DW*ch +: DW]);
                m_has[ch]   = 1'b1;
                m_start[ch] = cyc;
                m_half[ch]  = h;
                m_bad[ch]   = bd;
                m_play[ch]  = (d == 0) ? 1 : d * BD;
                m_busy[ch]  = m_play[ch] + GAP_LEN;
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #2;
    endtask

    typedef struct {
        int          ch;
        logic [11:0] code;
        int          dur;
        int          half;   // clocks before the first rise (0 = never rises)
        int          tog;    // tone edges while playing
        int          bad;    // bad_code pulses
        int          busy;   // play length without any gap
    } vec_t;

    task automatic play_entry(input vec_t v);
        int  busy_n, rise, tog, badn, ended, done_end, tone_end;
        bit  last;
        busy_n = 0; rise = 0; tog = 0; badn = 0; ended = 0; done_end = 0; tone_end = 1; last = 0;
        next();
        bus.note_valid[v.ch] = 1'b1;
        bus.note_code[12*v.ch +: 12] = v.code;
        bus.note_dur[DW*v.ch +: DW] = DW'(v.dur);
        next();
        bus.note_valid[v.ch] = 1'b0;
        bus.note_code[12*v.ch +: 12] = 12'($urandom);
        bus.note_dur[DW*v.ch +: DW] = DW'($urandom);
        for (int c = 1; c <= v.busy + GAP_LEN + 10; c++) begin
            @(negedge clk);
            if (!bus.busy[v.ch]) begin
                ended = 1; done_end = int'(bus.note_done[v.ch]); tone_end = int'(bus.tone_out[v.ch]);
                break;
            end
            busy_n++;
            if (bus.bad_code[v.ch]) badn++;
            if (c <= v.busy && bus.tone_out[v.ch] != last) begin
                tog++;
                if (rise == 0 && bus.tone_out[v.ch]) rise = c - 1;
                last = bus.tone_out[v.ch];
            end
        end
        check($sformatf("note_%03h_ended", v.code), ended, 1);
        check($sformatf("note_%03h_busy_len", v.code), busy_n, v.busy + GAP_LEN);
        check($sformatf("note_%03h_first_rise", v.code), rise, v.half);
        check($sformatf("note_%03h_toggles", v.code), tog, v.tog);
        check($sformatf("note_%03h_bad_pulses", v.code), badn, v.bad);
        check($sformatf("note_%03h_done_at_end", v.code), done_end, 1);
        check($sformatf("note_%03h_tone_at_end", v.code), tone_end, 0);
    endtask

    vec_t vecs [8];

    initial begin
        int found, mm, mix_hi, dn;
        bit prev_or;
        vecs[0] = '{0, 12'h700, 2, 1520, 5, 0, 8000};
        vecs[1] = '{0, 12'h070, 1, 3038, 1, 0, 4000};
        vecs[2] = '{1, 12'h100, 1, 2868, 1, 0, 4000};
        vecs[3] = '{0, 12'h000, 1, 0,    0, 0, 4000};
        vecs[4] = '{1, 12'h011, 0, 0,    0, 1, 1};
        vecs[5] = '{1, 12'h008, 0, 0,    0, 1, 1};
        vecs[6] = '{0, 12'h900, 0, 0,    0, 1, 1};
        vecs[7] = '{0, 12'h001, 0, 0,    0, 0, 1};

        rst = 1'b1;
        bus.note_valid = '0;
        bus.note_code  = '0;
        bus.note_dur   = '0;
        next();
        chk_en = 1'b1;
        next();
        @(negedge clk);
        check("reset_ready", bus.note_ready, 3);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.note_done, 0);
        check("reset_bad", bus.bad_code, 0);
        check("reset_tone", bus.tone_out, 0);
        check("reset_mix", bus.tone_mix, 0);
        next();
        rst = 1'b0;

        for (int i = 0; i < 8; i++) play_entry(vecs[i]);

        // Both channels with valid held high: back-to-back accept on the done cycle.
        next();
        bus.note_code = {12'h100, 12'h001};
        bus.note_dur  = {8'd1, 8'd1};
        bus.note_valid = 2'b11;
        found = 0;
        for (int c = 0; c < BD + GAP_LEN + 20; c++) begin
            @(negedge clk);
            if (bus.note_done[0]) begin found = 1; break; end
        end
        check("b2b_done_seen", found, 1);
        check("b2b_ready_on_done", bus.note_ready[0], 1);
        prev_or = |bus.tone_out;
        @(negedge clk);
        check("b2b_busy_next", bus.busy[0], 1);
        mm = 0; mix_hi = 0;
        for (int c = 0; c < 3000; c++) begin
            if (bus.tone_mix !== prev_or) mm++;
            if (bus.tone_mix) mix_hi++;
            prev_or = |bus.tone_out;
            @(negedge clk);
        end
        check("mix_or_delayed", mm, 0);
        check("mix_went_high", int'(mix_hi > 0), 1);
        next();
        bus.note_valid = 2'b00;
        found = 0;
        for (int c = 0; c < 2 * (BD + GAP_LEN) + 20; c++) begin
            @(negedge clk);
            if (bus.busy == 2'b00) begin found = 1; break; end
        end
        check("b2b_drain", found, 1);

        // Reset in the middle of a sounding note.
        next();
        bus.note_code[11:0] = 12'h700;
        bus.note_dur[7:0]   = 8'd2;
        bus.note_valid[0]   = 1'b1;
        next();
        bus.note_valid[0] = 1'b0;
        repeat (2000) next();
        rst = 1'b1;
        next();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready", bus.note_ready, 3);
        check("midrst_busy", bus.busy, 0);
        check("midrst_tone", bus.tone_out, 0);
        check("midrst_mix", bus.tone_mix, 0);
        dn = int'(bus.note_done != 0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.note_done != 0) dn++;
        end
        check("midrst_no_done", dn, 0);

        // Random traffic, checked cycle by cycle by the timeline model.
        for (int c = 0; c < 10000; c++) begin
            next();
            rst = ($urandom_range(0, 2999) == 0);
            for (int ch = 0; ch < NCH; ch++) begin
                logic [11:0] cd;
                int sel;
                bus.note_valid[ch] = ($urandom_range(0, 7) == 0);
                sel = int'($urandom_range(0, 3));
                if (sel < 2)       cd = 12'($urandom_range(1, 7)) << (4 * $urandom_range(0, 2));
                else if (sel == 2) cd = 12'h000;
                else               cd = 12'($urandom);
                bus.note_code[12*ch +: 12] = cd;
                bus.note_dur[DW*ch +: DW]  = ($urandom_range(0, 5) == 0) ? 8'd1 : 8'd0;
            end
        end
        next();
        rst = 1'b0;
        bus.note_valid = 2'b00;
        found = 0;
        for (int c = 0; c < BD + GAP_LEN + 20; c++) begin
            @(negedge clk);
            if (bus.busy == 2'b00) begin found = 1; break; end
        end
        check("random_drain", found, 1);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
